seq_digital_lock: RTL and testbench

SEQ_DIGITAL_LOCK -- requirements
Module: seq_digital_lock

---
 rtl/seq_digital_lock.sv | 215 +++++++++++++++++++++
 tb/tb_seq_digital_lock.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_digital_lock.sv
// ---------------------------------------------------------------------------
// seq_digital_lock
//   Sequential keypad lock. Digits are shifted into an entry buffer (first
//   digit ends up most significant). The attempt is submitted with enter and
//   compared against the stored code. A match opens the lock for
//   UNLOCK_CYCLES cycles. MAX_TRIES consecutive failures start a lockout of
//   LOCKOUT_CYCLES cycles, during which all inputs are ignored.
//
//   Optional feature macro: SEQ_DIGITAL_LOCK_PROG_EN
//     Adds the prog input and a PROG state. From OPEN, prog lets a new code
//     be entered and stored. Without the macro the code is fixed to
//     DEFAULT_CODE.
//
//   State table
//     state   | meaning
//     IDLE    | no digits held, waiting for the first digit or enter
//     ENTRY   | collecting digits (count saturates at CODE_LEN)
//     OPEN    | unlock high, timer counting down UNLOCK_CYCLES
//     LOCKOUT | alarm/locked_out high, timer counting down LOCKOUT_CYCLES
//     PROG    | (macro only) collecting a new code
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   digit_valid in   digit strobe
//   digit       in   digit value [DIGIT_W]
//   enter       in   submit attempt
//   cancel      in   abort entry / relock
//   prog        in   (macro only) start reprogramming from OPEN
//   unlock      out  lock is open
//   alarm       out  raised during lockout
//   locked_out  out  lockout timer running
//   fail_count  out  consecutive failed attempts
// ---------------------------------------------------------------------------
module seq_digital_lock #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'hA5C3,
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 50,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           digit_valid,
    input  logic [DIGIT_W-1:0]             digit,
    input  logic                           enter,
    input  logic                           cancel,
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
    input  logic                           prog,
`endif
    output logic                           unlock,
    output logic                           alarm,
    output logic                           locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

    localparam int CW   = CODE_LEN * DIGIT_W;
    localparam int NW   = $clog2(CODE_LEN + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

`ifdef SEQ_DIGITAL_LOCK_PROG_EN
    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_OPEN, S_LOCKOUT, S_PROG} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_OPEN, S_LOCKOUT} state_t;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   buffer, buffer_n;
    logic [NW-1:0]   count, count_n;
    logic [FW-1:0]   fail_n;
    logic [TW-1:0]   timer, timer_n;
    logic [CW-1:0]   code;
    logic            unlock_n, alarm_n;

    logic [CW-1:0]   buf_shift;
    logic            dig_ok;
    logic            full;
    logic            match;
    logic [FW-1:0]   fail_inc;

`ifdef SEQ_DIGITAL_LOCK_PROG_EN
    logic [CW-1:0]   code_n;
`else
    assign code = DEFAULT_CODE;
`endif

    assign buf_shift = (buffer << DIGIT_W) | CW'(digit);
    assign full      = (count == NW'(CODE_LEN));
    assign dig_ok    = digit_valid && !full;
    assign match     = full && (buffer == code);
    assign fail_inc  = fail_count + FW'(1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            buffer     <= '0;
            count      <= '0;
            fail_count <= '0;
            timer      <= '0;
            unlock     <= 1'b0;
            alarm      <= 1'b0;
            locked_out <= 1'b0;
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
            code       <= DEFAULT_CODE;
`endif
        end else begin
            state      <= state_n;
            buffer     <= buffer_n;
            count      <= count_n;
            fail_count <= fail_n;
            timer      <= timer_n;
            unlock     <= unlock_n;
            alarm      <= alarm_n;
            locked_out <= alarm_n;
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
            code       <= code_n;
`endif
        end
    end

    // Next-state and datapath logic; cancel > enter > digit_valid
    always_comb begin
        state_n  = state;
        buffer_n = buffer;
        count_n  = count;
        fail_n   = fail_count;
        timer_n  = timer;
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
        code_n   = code;
`endif
        case (state)
            S_IDLE, S_ENTRY: begin
                if (cancel) begin
                    state_n  = S_IDLE;
                    buffer_n = '0;
                    count_n  = '0;
                end else if (enter) begin
                    buffer_n = '0;
                    count_n  = '0;
                    if (match) begin
                        state_n = S_OPEN;
                        fail_n  = '0;
                        timer_n = TW'(UNLOCK_CYCLES - 1);
                    end else begin
                        fail_n = fail_inc;
                        if (fail_inc == FW'(MAX_TRIES)) begin
                            state_n = S_LOCKOUT;
                            timer_n = TW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                end else if (dig_ok) begin
                    state_n  = S_ENTRY;
                    buffer_n = buf_shift;
                    count_n  = count + NW'(1);
                end
            end
            S_OPEN: begin
                if (cancel) begin
                    state_n = S_IDLE;
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
                end else if (prog) begin
                    state_n = S_PROG;
`endif
                end else if (timer == '0) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer == '0) begin
                    state_n = S_IDLE;
                    fail_n  = '0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
            S_PROG: begin
                if (cancel) begin
                    state_n  = S_IDLE;
                    buffer_n = '0;
                    count_n  = '0;
                end else if (enter) begin
                    if (full) code_n = buffer;
                    state_n  = S_IDLE;
                    buffer_n = '0;
                    count_n  = '0;
                end else if (dig_ok) begin
                    buffer_n = buf_shift;
                    count_n  = count + NW'(1);
                end
            end
`endif
            default: begin
                state_n  = S_IDLE;
                buffer_n = '0;
                count_n  = '0;
            end
        endcase
    end

    // Outputs are registered copies of the decoded next state
    always_comb begin
        unlock_n = (state_n == S_OPEN);
        alarm_n  = (state_n == S_LOCKOUT);
    end

endmodule

// File: tb/tb_seq_digital_lock.sv
module tb_seq_digital_lock;
    localparam int DIGIT_W  = 4;
    localparam int CODE_LEN = 4;
    localparam int MAX_T    = 3;
    localparam int UNL      = 4;
    localparam int LCK      = 8;
    localparam int FW       = $clog2(MAX_T + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               digit_valid = 1'b0;
    logic [DIGIT_W-1:0] digit = '0;
    logic               enter = 1'b0;
    logic               cancel = 1'b0;
    logic               prog = 1'b0;
    logic               unlock, alarm, locked_out;
    logic [FW-1:0]      fail_count;

    seq_digital_lock #(
        .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .DEFAULT_CODE(16'hA5C3),
        .MAX_TRIES(MAX_T), .UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK)
    ) dut (
        .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .enter(enter), .cancel(cancel),
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
        .prog(prog),
`endif
        .unlock(unlock), .alarm(alarm), .locked_out(locked_out),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: digits held in a queue, timers as remaining-cycle counts
    int  m_digits[$];
    int  m_code[CODE_LEN];
    int  m_fails;
    int  m_open_left;
    int  m_lock_left;
    bit  m_prog_mode;

    task automatic model_reset();
        m_digits.delete();
        m_code = '{10, 5, 12, 3};
        m_fails = 0;
        m_open_left = 0;
        m_lock_left = 0;
        m_prog_mode = 0;
    endtask

    function automatic bit model_match();
        if (m_digits.size() != CODE_LEN) return 0;
        for (int i = 0; i < CODE_LEN; i++)
            if (m_digits[i] != m_code[i]) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit r, dv, input int d, input bit en, ca, pr);
        if (r) begin
            model_reset();
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_open_left > 0) begin
            if (ca) m_open_left = 0;
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
            else if (pr) begin m_open_left = 0; m_prog_mode = 1; end
`endif
            else m_open_left--;
        end else if (ca) begin
            m_digits.delete();
            m_prog_mode = 0;
        end else if (en) begin
            if (m_prog_mode) begin
                if (m_digits.size() == CODE_LEN)
                    for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_digits[i];
                m_prog_mode = 0;
            end else if (model_match()) begin
                m_open_left = UNL;
                m_fails = 0;
            end else begin
                m_fails++;
                if (m_fails == MAX_T) m_lock_left = LCK;
            end
            m_digits.delete();
        end else if (dv && m_digits.size() < CODE_LEN) begin
            m_digits.push_back(d % 16);
        end
    endtask

    task automatic tick(input bit r, dv, input int d, input bit en, ca, pr);
        reset = r; digit_valid = dv; digit = DIGIT_W'(d); enter = en; cancel = ca;
        prog = pr;
        @(posedge clk);
        model_step(r, dv, d, en, ca, pr);
        #1;
        check("unlock", unlock, (m_open_left > 0) ? 1 : 0);
        check("alarm", alarm, (m_lock_left > 0) ? 1 : 0);
        check("locked_out", locked_out, (m_lock_left > 0) ? 1 : 0);
        check("fail_count", fail_count, m_fails);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
    endtask
    task automatic press(input int d);
        tick(0, 1, d, 0, 0, 0);
    endtask
    task automatic do_reset();
        tick(1, 0, 0, 0, 0, 0);
    endtask
    task automatic press4(input int a, b, c, e);
        press(a); press(b); press(c); press(e);
    endtask

    int hi;

    initial begin
        model_reset();
        #1;
        // reset state
        do_reset();
        check("rst_unlock", unlock, 0);
        check("rst_fail", fail_count, 0);

        // correct code opens for exactly UNL cycles
        press4(10, 5, 12, 3);
        tick(0, 0, 0, 1, 0, 0);
        check("open_rise", unlock, 1);
        check("open_fail0", fail_count, 0);
        hi = 1;
        for (int i = 0; i < UNL + 3; i++) begin idle(1); hi += unlock; end
        check("open_len", hi, UNL);

        // three wrong attempts -> lockout for LCK cycles
        do_reset();
        for (int t = 1; t <= 3; t++) begin
            press4(10, 5, 12, 2);
            tick(0, 0, 0, 1, 0, 0);
            check("fail_step", fail_count, t);
        end
        check("lock_alarm", alarm, 1);
        hi = 1;
        for (int i = 0; i < LCK + 3; i++) begin
            tick(0, 1, 3, (i % 2), (i % 3 == 0), 0);
            hi += alarm;
        end
        check("lock_len", hi, LCK);
        check("lock_clear", fail_count, 0);

        // fifth digit ignored; short code fails
        do_reset();
        press4(10, 5, 12, 3); press(7);
        tick(0, 0, 0, 1, 0, 0);
        check("long_open", unlock, 1);
        tick(0, 0, 0, 0, 1, 0);
        check("cancel_open", unlock, 0);
        press(10); press(5); press(12);
        tick(0, 0, 0, 1, 0, 0);
        check("short_fail", fail_count, 1);

        // enter with digit_valid: digit dropped, code matches
        do_reset();
        press4(10, 5, 12, 3);
        tick(0, 1, 9, 1, 0, 0);
        check("en_dv_open", unlock, 1);
        tick(0, 0, 0, 0, 1, 0);
        // cancel with enter: no attempt counted
        press4(10, 5, 12, 2);
        tick(0, 0, 0, 1, 0, 0);
        press(10); press(5);
        tick(0, 0, 0, 1, 1, 0);
        check("cancel_en", fail_count, 1);
        press4(10, 5, 12, 3);
        tick(0, 0, 0, 1, 0, 0);
        check("after_cancel_open", unlock, 1);

        // reset during OPEN and during LOCKOUT
        idle(1);
        do_reset();
        check("rst_open", {unlock, alarm, locked_out, fail_count}, 0);
        for (int t = 0; t < 3; t++) begin press(1); tick(0, 0, 0, 1, 0, 0); end
        idle(2);
        do_reset();
        check("rst_lock", {unlock, alarm, locked_out, fail_count}, 0);

`ifdef SEQ_DIGITAL_LOCK_PROG_EN
        press4(10, 5, 12, 3);
        tick(0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        check("prog_drop", unlock, 0);
        press4(1, 2, 3, 4);
        tick(0, 0, 0, 1, 0, 0);
        press4(1, 2, 3, 4);
        tick(0, 0, 0, 1, 0, 0);
        check("prog_new_open", unlock, 1);
        tick(0, 0, 0, 0, 1, 0);
        press4(10, 5, 12, 3);
        tick(0, 0, 0, 1, 0, 0);
        check("prog_old_fail", fail_count, 1);
        do_reset();
`endif

        // randomized attempts against the model
        for (int a = 0; a < 150; a++) begin
            int kind = $urandom_range(0, 9);
            int len  = (kind < 5) ? CODE_LEN : $urandom_range(0, CODE_LEN + 2);
            for (int i = 0; i < len; i++) begin
                int d = (kind < 5 && i < CODE_LEN) ? m_code[i] : $urandom_range(0, 15);
                idle($urandom_range(0, 1));
                tick(0, 1, d, ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0), 0);
            end
            tick(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 15), 1,
                 ($urandom_range(0, 15) == 0), 0);
            for (int i = $urandom_range(0, 10); i > 0; i--)
                tick(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 15), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 11) == 0),
`ifdef SEQ_DIGITAL_LOCK_PROG_EN
                     ($urandom_range(0, 9) == 0)
`else
                     0
`endif
                    );
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
